pipe_adder: RTL and testbench

- Parametrised, pipelined add/subtract unit; successor to the fixed 5-bit combinational adder on the board top.
- Operands are split into CHUNK-bit slices. One slice is resolved per pipeline stage, with the carry registered between stages.
- Valid/ready handshake on input and output, so it can sit between switch-sampling logic and the 7-segment/LED display path, or inside a datapath.
- Adds subtract mode, a zero flag and full backpressure.

---
 rtl/pipe_adder_pkg.sv | 23 ++
 rtl/adder_chunk.sv | 16 +
 rtl/pipe_adder.sv | 101 ++++++++++
 tb/tb_pipe_adder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared helpers for the pipelined add/subtract unit: stage-count math and
// the control portion of the per-stage record.
package pipe_adder_pkg;

  // Operand and result widths vary per stage, so only the fixed-width
  // control fields live here; data widths are localparams in pipe_adder.
  typedef struct packed {
    logic valid;
    logic carry;
    logic sub;
  } stage_ctl_t;

  function automatic int n_stages(input int w, input int chunk);
    return (w + chunk - 1) / chunk;
  endfunction

  function automatic int slice_width(input int w, input int chunk, input int k);
    int rem;
    rem = w - k * chunk;
    return (rem < chunk) ? rem : chunk;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit slice adder with carry in/out.
module adder_chunk
  import pipe_adder_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + (CW+1)'(ci);

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: one CHUNK-bit slice per stage, carry registered
// between stages, global-enable valid/ready handshake.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int W     = 8,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   sum,
  output logic         zero
);

  localparam int STAGES = n_stages(W, CHUNK);

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CHUNK;
    localparam int CW = slice_width(W, CHUNK, k);
    localparam int OW = W - LO;   // operand bits still unresolved entering this stage
    localparam int DW = LO + CW;  // result bits known after this stage
    localparam int PK = (k > 0) ? k - 1 : 0;

    logic [OW-1:0] a_op, b_op;
    logic          ci, v_in, m_in;
    logic [CW-1:0] s_slice;
    logic          co;
    logic [DW-1:0] s_nxt, s_q;
    stage_ctl_t    ctl_q;

    if (k == 0) begin : g_head
      assign a_op  = a;
      assign b_op  = b ^ {W{sub}};
      assign ci    = sub;
      assign v_in  = in_valid;
      assign m_in  = sub;
      assign s_nxt = s_slice;
    end else begin : g_body
      // Upper operand bits ride along with the beat; the slice just consumed
      // by the previous stage is dropped.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_op <= '0;
          b_op <= '0;
        end else if (adv) begin
          a_op <= g_st[PK].a_op[OW+CHUNK-1:CHUNK];
          b_op <= g_st[PK].b_op[OW+CHUNK-1:CHUNK];
        end
      end
      assign ci    = g_st[PK].ctl_q.carry;
      assign v_in  = g_st[PK].ctl_q.valid;
      assign m_in  = g_st[PK].ctl_q.sub;
      assign s_nxt = {s_slice, g_st[PK].s_q};
    end

    adder_chunk #(.CW(CW)) u_add (
      .x  (a_op[CW-1:0]),
      .y  (b_op[CW-1:0]),
      .ci (ci),
      .s  (s_slice),
      .co (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_q <= '0;
        s_q   <= '0;
      end else if (adv) begin
        ctl_q <= '{valid: v_in, carry: co, sub: m_in};
        s_q   <= s_nxt;
      end
    end

    if (k == STAGES - 1) begin : g_tail
      logic zero_q;

      // Top bit is carry for add and borrow (inverted carry) for subtract.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   zero_q <= 1'b0;
        else if (adv) zero_q <= ({co ^ m_in, s_nxt} == '0);
      end

      assign out_valid = ctl_q.valid;
      assign sum       = {ctl_q.carry ^ ctl_q.sub, s_q};
      assign zero      = zero_q;
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder at W=8/CHUNK=4, W=10/CHUNK=4 and W=10/CHUNK=16.
module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       v0, r0, s0, ov0, or0, z0;
  logic [7:0] a0, b0;
  logic [8:0] sum0;

  logic        v1, r1, s1, ov1, or1, z1;
  logic [9:0]  a1, b1;
  logic [10:0] sum1;

  logic        v2, r2, s2, ov2, or2, z2;
  logic [9:0]  a2, b2;
  logic [10:0] sum2;

  pipe_adder #(.W(8), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .a(a0), .b(b0),
    .sub(s0), .out_valid(ov0), .out_ready(or0), .sum(sum0), .zero(z0)
  );

  pipe_adder #(.W(10), .CHUNK(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .a(a1), .b(b1),
    .sub(s1), .out_valid(ov1), .out_ready(or1), .sum(sum1), .zero(z1)
  );

  pipe_adder #(.W(10), .CHUNK(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .a(a2), .b(b2),
    .sub(s2), .out_valid(ov2), .out_ready(or2), .sum(sum2), .zero(z2)
  );

  task automatic test_reset();
    v0 = 1'b1; a0 = 8'd3; b0 = 8'd4; s0 = 1'b0; or0 = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ov0 !== 1'b0) begin failures++; $display("FAIL rst_hold_out_valid got %b want 0", ov0); end
    v0 = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (ov0 !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b want 0", ov0); end
    checks++;
    if (sum0 !== 9'h000) begin failures++; $display("FAIL rst_sum got %h want 000", sum0); end
    checks++;
    if (z0 !== 1'b0) begin failures++; $display("FAIL rst_zero got %b want 0", z0); end
    checks++;
    if (r0 !== 1'b1) begin failures++; $display("FAIL rst_in_ready got %b want 1", r0); end
    checks++;
    if (r1 !== 1'b1 || r2 !== 1'b1) begin
      failures++; $display("FAIL rst_in_ready_wide got %b%b want 11", r1, r2);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (ov0 !== 1'b0) begin failures++; $display("FAIL rst_idle_out_valid[%0d] got %b want 0", c, ov0); end
    end
  endtask

  task automatic test_add();
    logic [7:0] va[3] = '{8'd200, 8'd255, 8'd0};
    logic [7:0] vb[3] = '{8'd100, 8'd255, 8'd0};
    logic [8:0] vs[3] = '{9'h12C, 9'h1FE, 9'h000};
    logic       vz[3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      int lat;
      lat = -1;
      @(negedge clk);
      v0 = 1'b1; a0 = va[i]; b0 = vb[i]; s0 = 1'b0; or0 = 1'b1;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        v0 = 1'b0; a0 = 8'hxx; b0 = 8'hxx;
        if (ov0 === 1'b1 && lat < 0) begin
          lat = c;
          checks++;
          if (sum0 !== vs[i]) begin failures++; $display("FAIL add_sum[%0d] got %h want %h", i, sum0, vs[i]); end
          checks++;
          if (z0 !== vz[i]) begin failures++; $display("FAIL add_zero[%0d] got %b want %b", i, z0, vz[i]); end
        end
      end
      checks++;
      if (lat != 2) begin failures++; $display("FAIL add_latency[%0d] got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_sub();
    logic [7:0] va[3] = '{8'd7, 8'd5, 8'd9};
    logic [7:0] vb[3] = '{8'd5, 8'd7, 8'd9};
    logic [8:0] vs[3] = '{9'h002, 9'h1FE, 9'h000};
    logic       vz[3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      int lat;
      lat = -1;
      @(negedge clk);
      v0 = 1'b1; a0 = va[i]; b0 = vb[i]; s0 = 1'b1; or0 = 1'b1;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        v0 = 1'b0; s0 = 1'bx;
        if (ov0 === 1'b1 && lat < 0) begin
          lat = c;
          checks++;
          if (sum0 !== vs[i]) begin failures++; $display("FAIL sub_sum[%0d] got %h want %h", i, sum0, vs[i]); end
          checks++;
          if (z0 !== vz[i]) begin failures++; $display("FAIL sub_zero[%0d] got %b want %b", i, z0, vz[i]); end
        end
      end
      checks++;
      if (lat != 2) begin failures++; $display("FAIL sub_latency[%0d] got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va[6] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd250, 8'd128};
    logic [7:0] vb[6] = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd10, 8'd128};
    logic       vsub[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [8:0] vs[6] = '{9'h00F, 9'h01A, 9'h017, 9'h030, 9'h104, 9'h100};
    int sent, got;
    logic exp_ready;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 24 && got < 6; cyc++) begin
      @(negedge clk);
      or0 = !(cyc >= 3 && cyc <= 5);
      v0  = (sent < 6);
      if (sent < 6) begin a0 = va[sent]; b0 = vb[sent]; s0 = vsub[sent]; end
      #1;
      exp_ready = !(cyc >= 3 && cyc <= 5);
      checks++;
      if (r0 !== exp_ready) begin
        failures++; $display("FAIL b2b_in_ready[cyc%0d] got %b want %b", cyc, r0, exp_ready);
      end
      if (ov0 === 1'b1) begin
        checks++;
        if (got > 5 || sum0 !== vs[got]) begin
          failures++; $display("FAIL b2b_sum[cyc%0d] got %h want %h", cyc, sum0, vs[got % 6]);
        end
      end
      if (ov0 === 1'b1 && or0) got++;
      if (v0 && r0 === 1'b1) sent++;
    end
    v0 = 1'b0; or0 = 1'b1;
    checks++;
    if (got != 6) begin failures++; $display("FAIL b2b_count got %0d want 6", got); end
    repeat (3) @(negedge clk);
    checks++;
    if (ov0 !== 1'b0) begin failures++; $display("FAIL b2b_drain_out_valid got %b want 0", ov0); end
  endtask

  task automatic test_wide_slices();
    int lat1, lat2;
    lat1 = -1; lat2 = -1;
    @(negedge clk);
    v1 = 1'b1; a1 = 10'd1023; b1 = 10'd1; s1 = 1'b0; or1 = 1'b1;
    v2 = 1'b1; a2 = 10'd1023; b2 = 10'd1; s2 = 1'b0; or2 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      v1 = 1'b0; v2 = 1'b0;
      if (ov1 === 1'b1 && lat1 < 0) begin
        lat1 = c;
        checks++;
        if (sum1 !== 11'h400) begin failures++; $display("FAIL w10c4_sum got %h want 400", sum1); end
      end
      if (ov2 === 1'b1 && lat2 < 0) begin
        lat2 = c;
        checks++;
        if (sum2 !== 11'h400) begin failures++; $display("FAIL w10c16_sum got %h want 400", sum2); end
      end
    end
    checks++;
    if (lat1 != 3) begin failures++; $display("FAIL w10c4_latency got %0d want 3", lat1); end
    checks++;
    if (lat2 != 1) begin failures++; $display("FAIL w10c16_latency got %0d want 1", lat2); end
  endtask

  task automatic test_reset_flush();
    @(negedge clk);
    v0 = 1'b1; a0 = 8'd1; b0 = 8'd2; s0 = 1'b0; or0 = 1'b1;
    @(negedge clk);
    a0 = 8'd3; b0 = 8'd4;
    @(negedge clk);
    v0 = 1'b0;
    checks++;
    if (ov0 !== 1'b1 || sum0 !== 9'h003) begin
      failures++; $display("FAIL flush_pre got valid=%b sum=%h want valid=1 sum=003", ov0, sum0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov0 !== 1'b0) begin failures++; $display("FAIL flush_async_out_valid got %b want 0", ov0); end
    checks++;
    if (sum0 !== 9'h000) begin failures++; $display("FAIL flush_async_sum got %h want 000", sum0); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (ov0 !== 1'b0) begin failures++; $display("FAIL flush_ghost[%0d] got %b want 0", c, ov0); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    v0 = 0; a0 = 0; b0 = 0; s0 = 0; or0 = 1;
    v1 = 0; a1 = 0; b1 = 0; s1 = 0; or1 = 1;
    v2 = 0; a2 = 0; b2 = 0; s2 = 0; or2 = 1;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_wide_slices();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
